// File: rtl/hbf_seq.sv
// Single-multiplier sequencer for the 7-tap halfband decimate-by-2 stage (34x16 MAC shared over 3 coefficient groups).
// Define HBF_SEQ_ROUND_EN for round-half-up output; otherwise the output is floor-truncated.
module hbf_seq #(
    parameter int                   SIZE = 15,
    parameter logic signed [SIZE:0] B0   = -16'sd2761,
    parameter logic signed [SIZE:0] B2   = 16'sd10053,
    parameter logic signed [SIZE:0] B3   = 16'sd16384
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [32:0] in_i,
    input  logic        valid_in_i,
    input  logic        clr_ovr_i,
    output logic [32:0] out_o,
    output logic        valid_out_o,
    output logic        busy_o,
    output logic        overrun_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_MUL0 = 3'd2,
        S_MUL1 = 3'd3,
        S_MUL2 = 3'd4,
        S_OUT  = 3'd5
    } state_e;

    state_e             state_q;
    logic signed [32:0] x_q [7];
    logic               phase_q;
    logic signed [33:0] pa_q, pb_q, pc_q;
    logic signed [52:0] acc_q;
    logic signed [32:0] out_q;
    logic               valid_out_q, busy_q, overrun_q;

    logic               trigger_s, drop_s;
    logic signed [33:0] mul_op_s;
    logic signed [SIZE:0] mul_coef_s;
    logic signed [52:0] prod_s, acc_d, rnd_s;
    logic signed [32:0] out_d;

    assign trigger_s = valid_in_i & phase_q;
    assign drop_s    = trigger_s & (state_q != S_IDLE);

    // Shared multiplier operand select, accumulate and output scaling
    always_comb begin
        mul_op_s   = pc_q;
        mul_coef_s = B3;
        case (state_q)
            S_MUL0: begin
                mul_op_s   = pa_q;
                mul_coef_s = B0;
            end
            S_MUL1: begin
                mul_op_s   = pb_q;
                mul_coef_s = B2;
            end
            default: begin
                mul_op_s   = pc_q;
                mul_coef_s = B3;
            end
        endcase
        prod_s = 53'(mul_op_s) * 53'(mul_coef_s);
        if (state_q == S_MUL0) begin
            acc_d = prod_s;
        end else begin
            acc_d = acc_q + prod_s;
        end
`ifdef HBF_SEQ_ROUND_EN
        rnd_s = acc_d + 53'sd16384;
`else
        rnd_s = acc_d;
`endif
        out_d = 33'(rnd_s >>> 6'd15);
    end

    // Input delay line and decimation phase
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < 7; k++) x_q[k] <= 33'sd0;
            phase_q <= 1'b0;
        end else if (valid_in_i) begin
            x_q[0] <= $signed(in_i);
            for (int k = 1; k < 7; k++) x_q[k] <= x_q[k-1];
            phase_q <= ~phase_q;
        end
    end

    // Sequencer FSM with operand capture, accumulator and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            pa_q        <= 34'sd0;
            pb_q        <= 34'sd0;
            pc_q        <= 34'sd0;
            acc_q       <= 53'sd0;
            out_q       <= 33'sd0;
            valid_out_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            valid_out_q <= 1'b0;
            // A dropped trigger in the same cycle as a clear keeps the flag set
            if (drop_s) begin
                overrun_q <= 1'b1;
            end else if (clr_ovr_i) begin
                overrun_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (trigger_s) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    pa_q    <= 34'(x_q[0]) + 34'(x_q[6]);
                    pb_q    <= 34'(x_q[2]) + 34'(x_q[4]);
                    pc_q    <= 34'(x_q[3]);
                    state_q <= S_MUL0;
                end
                S_MUL0: begin
                    acc_q   <= acc_d;
                    state_q <= S_MUL1;
                end
                S_MUL1: begin
                    acc_q   <= acc_d;
                    state_q <= S_MUL2;
                end
                S_MUL2: begin
                    acc_q       <= acc_d;
                    out_q       <= out_d;
                    valid_out_q <= 1'b1;
                    state_q     <= S_OUT;
                end
                S_OUT: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_o       = out_q;
    assign valid_out_o = valid_out_q;
    assign busy_o      = busy_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_hbf_seq.sv
// Self-checking bench for hbf_seq: directed sections plus random traffic against a cycle-level reference model.
module tb_hbf_seq;

    localparam longint C_B0 = -2761;
    localparam longint C_B2 = 10053;
    localparam longint C_B3 = 16384;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [32:0] in_v = 33'd0;
    logic        valid_in = 1'b0;
    logic        clr_ovr = 1'b0;
    logic [32:0] out_v;
    logic        valid_out, busy, overrun;

    always #5 clk = ~clk;

    hbf_seq dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_i       (in_v),
        .valid_in_i (valid_in),
        .clr_ovr_i  (clr_ovr),
        .out_o      (out_v),
        .valid_out_o(valid_out),
        .busy_o     (busy),
        .overrun_o  (overrun)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: sample history, phase, FSM-free window and pending outputs
    longint hist [7];
    int     phase_m;
    longint cyc = 0;
    longint free_from;
    longint pend_cyc [$];
    longint pend_val [$];
    longint last_out;
    bit     ovr_m;
    longint seen [$];

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint ref_y();
        longint s, q;
        s = (hist[0] + hist[6]) * C_B0 + (hist[2] + hist[4]) * C_B2 + hist[3] * C_B3;
`ifdef HBF_SEQ_ROUND_EN
        s = s + 16384;
`endif
        q = s / 32768;
        if ((s % 32768 != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 7; k++) hist[k] = 0;
        phase_m   = 0;
        free_from = 0;
        pend_cyc.delete();
        pend_val.delete();
        last_out  = 0;
        ovr_m     = 1'b0;
    endtask

    task automatic model_edge(input bit v, input longint d, input bit c);
        bit trig, dropped;
        trig    = v && (phase_m == 1);
        dropped = trig && (cyc < free_from);
        if (v) begin
            for (int k = 6; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = d;
            phase_m = 1 - phase_m;
        end
        if (trig && !dropped) begin
            pend_cyc.push_back(cyc + 5);
            pend_val.push_back(ref_y());
            free_from = cyc + 6;
        end
        if (dropped) ovr_m = 1'b1;
        else if (c) ovr_m = 1'b0;
        cyc++;
    endtask

    task automatic check_outputs();
        bit ev, busy_exp;
        ev       = (pend_cyc.size() > 0) && (pend_cyc[0] == cyc);
        busy_exp = (cyc >= free_from - 5) && (cyc < free_from);
        chk("valid_out", 64'(valid_out), 64'(ev));
        if (ev) begin
            last_out = pend_val.pop_front();
            void'(pend_cyc.pop_front());
        end
        chk("out", 64'($signed(out_v)), last_out);
        chk("busy", 64'(busy), 64'(busy_exp));
        chk("overrun", 64'(overrun), 64'(ovr_m));
        if (valid_out === 1'b1) seen.push_back(64'($signed(out_v)));
    endtask

    task automatic step(input bit v, input longint d, input bit c);
        valid_in = v;
        in_v     = d[32:0];
        clr_ovr  = c;
        @(posedge clk);
        model_edge(v, d, c);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic spaced(input longint d, input int gap);
        step(1'b1, d, 1'b0);
        repeat (gap - 1) step(1'b0, 0, 1'b0);
    endtask

    task automatic chk_seen(input string tag, input int idx, input longint exp);
        logic signed [63:0] obs;
        obs = (idx < seen.size()) ? seen[idx] : 'x;
        chk(tag, obs, exp);
    endtask

    initial begin
        longint d;
        model_reset();
        #1;
        chk("rst_out", 64'($signed(out_v)), 0);
        chk("rst_valid", 64'(valid_out), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_overrun", 64'(overrun), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1'b0, 0, 1'b0);

        // Impulse response: 0, 32768, then zeros every 4 cycles
        seen.delete();
        spaced(0, 4);
        spaced(32768, 4);
        repeat (10) spaced(0, 4);
        repeat (4) step(1'b0, 0, 1'b0);
        chk("imp_count", seen.size(), 6);
        chk_seen("imp_y0", 0, -2761);
        chk_seen("imp_y1", 1, 10053);
        chk_seen("imp_y2", 2, 10053);
        chk_seen("imp_y3", 3, -2761);
        chk_seen("imp_y4", 4, 0);

        // Constant input every 3 cycles: settles at 945, no overrun
        seen.delete();
        repeat (20) spaced(1000, 3);
        repeat (6) step(1'b0, 0, 1'b0);
        chk("dc_count", seen.size(), 10);
        chk_seen("dc_last", 9, 945);
        chk("dc_overrun", 64'(overrun), 0);

        // Back-to-back samples: triggers inside the busy window are dropped
        seen.delete();
        for (int i = 0; i < 8; i++) step(1'b1, longint'($urandom_range(0, 65535)) - 32768, 1'b0);
        repeat (8) step(1'b0, 0, 1'b0);
        chk("ovr_count", seen.size(), 2);
        chk("ovr_set", 64'(overrun), 1);
        step(1'b0, 0, 1'b1);
        chk("ovr_clr", 64'(overrun), 0);
        for (int i = 0; i < 8; i++) step(1'b1, longint'($urandom_range(0, 65535)) - 32768, 1'b0);
        repeat (8) step(1'b0, 0, 1'b0);

        // Reset asserted while the sequencer is in MUL1
        step(1'b1, 4000, 1'b0);
        step(1'b1, -3000, 1'b0);
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        chk("mid_busy", 64'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_out", 64'($signed(out_v)), 0);
        chk("mid_valid", 64'(valid_out), 0);
        chk("mid_busy0", 64'(busy), 0);
        chk("mid_overrun", 64'(overrun), 0);
        model_reset();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) step(1'b0, 0, 1'b0);

        // Rounding: +1 then -1 landing on the centre tap
        seen.delete();
        spaced(1, 4);
        repeat (7) spaced(0, 4);
        spaced(-1, 4);
        repeat (3) spaced(0, 4);
        repeat (4) step(1'b0, 0, 1'b0);
        chk("rnd_count", seen.size(), 6);
`ifdef HBF_SEQ_ROUND_EN
        chk_seen("rnd_pos", 1, 1);
        chk_seen("rnd_neg", 5, 0);
`else
        chk_seen("rnd_pos", 1, 0);
        chk_seen("rnd_neg", 5, -1);
`endif

        // Random traffic with varying density and occasional clears
        for (int i = 0; i < 3000; i++) begin
            d = longint'($urandom_range(0, 32'h7fff_ffff)) - 64'sd1073741824;
            step(($urandom_range(0, (i / 500) % 3 + 1) == 0), d, ($urandom_range(0, 15) == 0));
        end
        repeat (8) step(1'b0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
